// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module   : serial_adder_ctrl (with the halfAdder bit-cell primitive)
// Brief    : Bit-serial N-bit adder. One full-adder cell, made from two
//            halfAdder instances plus an OR, is reused LSB-first over WIDTH
//            cycles under a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Half adder: the shared building block of the serial bit cell.
module halfAdder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8            // operand/result width, 2..32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  // Bit counter width is derived from WIDTH; it must not be set separately.
  localparam int                CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] s_sr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Shared full-adder cell: two half adders, carry-out is the OR of both carries.
  logic ha0_s, ha0_c, ha1_c, bit_s, bit_c;

  halfAdder u_ha0 (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  halfAdder u_ha1 (
    .a_i (ha0_s),
    .b_i (carry_q),
    .s_o (bit_s),
    .c_o (ha1_c)
  );

  assign bit_c = ha0_c | ha1_c;

  // Control FSM and serial datapath; outputs are registered alongside state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_sr_q  <= a_i;
            b_sr_q  <= b_i;
            carry_q <= cin_i;
            s_sr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          s_sr_q  <= {bit_s, s_sr_q[WIDTH-1:1]};
          carry_q <= bit_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            // Final bit: publish the result in the same edge as DONE entry.
            sum_q   <= {bit_s, s_sr_q[WIDTH-1:1]};
            cout_q  <= bit_c;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Brief    : Directed, table-driven and random bench for serial_adder_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp = 0;
  int n_bad = 0;

  // Values sum/cout must hold between completions.
  logic [W-1:0] hold_sum;
  logic         hold_cout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [8];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .start_i   (start),
    .a_i       (a),
    .b_i       (b),
    .cin_i     (cin),
    .busy_o    (busy),
    .done_o    (done),
    .sum_o     (sum),
    .cout_o    (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation with handshake, latency and hold checks.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W-1:0] es,
                        input logic ec, input string name);
    int  lat;
    bit  stable;
    bit  got;
    a = ta; b = tb; cin = tc; start = 1'b1;
    tick();                       // accept edge k
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({name, " busy after accept"}, 32'(busy), 32'd1);
    stable = 1'b1;
    got    = 1'b0;
    lat    = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done) begin
        lat = n;
        got = 1'b1;
        break;
      end
      if (sum !== hold_sum || cout !== hold_cout || busy !== 1'b1) stable = 1'b0;
    end
    chk({name, " hold/busy during ADD"}, 32'(stable), 32'd1);
    chk({name, " done latency"}, 32'(got ? lat : 99), 32'(W));
    chk({name, " sum"}, 32'(sum), 32'(es));
    chk({name, " cout"}, 32'(cout), 32'(ec));
    tick();
    chk({name, " done one cycle"}, 32'(done), 32'd0);
    chk({name, " busy cleared"}, 32'(busy), 32'd0);
    hold_sum  = es;
    hold_cout = ec;
  endtask

  initial begin
    logic [W:0] model;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           dcount;
    int           d_at [2];
    logic [W-1:0] d_sum [2];
    logic         d_cout [2];

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    // Reset held with random inputs.
    reset_n = 1'b0; start = 1'b1;
    a = 8'h5A; b = 8'hC3; cin = 1'b1;
    hold_sum = '0; hold_cout = 1'b0;
    repeat (3) tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum",  32'(sum),  32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    start = 1'b0;
    reset_n = 1'b1;
    tick();

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
             $sformatf("vec%0d", i));

    // Asynchronous reset while idle with a nonzero held result.
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async idle reset sum",  32'(sum),  32'd0);
    chk("async idle reset cout", 32'(cout), 32'd0);
    hold_sum = '0; hold_cout = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // start held high continuously; operands changed during ADD.
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick();                       // first accept
    a = 8'hAA; b = 8'h55;
    dcount = 0;
    d_at[0] = 0; d_at[1] = 0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (i == 9)  chk("held start idle gap busy", 32'(busy), 32'd0);
      if (i == 10) begin
        chk("held start re-accept busy", 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (done) begin
        if (dcount < 2) begin
          d_at[dcount]   = i;
          d_sum[dcount]  = sum;
          d_cout[dcount] = cout;
        end
        dcount++;
      end
    end
    chk("held start done count", 32'(dcount), 32'd2);
    chk("held start 1st done cycle", 32'(d_at[0]), 32'd8);
    chk("held start 2nd done cycle", 32'(d_at[1]), 32'd18);
    chk("held start 1st sum",  32'(d_sum[0]),  32'h03);
    chk("held start 1st cout", 32'(d_cout[0]), 32'd0);
    chk("held start 2nd sum",  32'(d_sum[1]),  32'hFF);
    chk("held start 2nd cout", 32'(d_cout[1]), 32'd0);
    hold_sum = 8'hFF; hold_cout = 1'b0;
    tick();

    // Reset in the middle of an operation: everything clears, no done.
    run_op(8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, "pre-abort");
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort sum",  32'(sum),  32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dcount++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) dcount++;
    end
    chk("abort no done", 32'(dcount), 32'd0);
    hold_sum = '0; hold_cout = 1'b0;
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "post-abort");

    // Random sweep against the reference model.
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op(ra, rb, rc, model[W-1:0], model[W], $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial addition sequencer: computes an N-bit sum by reusing one 1-bit full-adder cell for N cycles.
- The bit cell is two instances of the team's existing halfAdder cell plus an OR for carry-out, so one adder is time-shared across all bit positions.
- A control FSM handles operand capture, the LSB-first shift schedule, carry storage and a start/done handshake.
- Sits between a requester (a test bench or a future ALU front-end) and the shared adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  registered result; holds its value between completions.
- cout  output  1  registered final carry; holds its value between completions.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry and counter = 0.
  - Takes effect immediately, including mid-operation. The in-flight operation is discarded and no done is produced.
- States: IDLE, ADD, DONE. All outputs are registered (Moore); busy and done decode from state.
- IDLE:
  - On an edge with start=1, capture a into a_sr, b into b_sr, cin into carry; clear s_sr and cnt; go to ADD.
  - With start=0, remain in IDLE.
- ADD, on each edge:
  - s = a_sr[0] ^ b_sr[0] ^ carry; c = majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right by 1 (zero fill).
  - s_sr shifts right with s inserted at the MSB.
  - carry <= c; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: load sum <= {s, s_sr[WIDTH-1:1]} and cout <= c; go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Timing:
  - Start accepted at edge k gives WIDTH ADD edges (k+1 .. k+WIDTH).
  - done is high from edge k+WIDTH to k+WIDTH+1, and sum/cout are valid from edge k+WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start is ignored in ADD and DONE. A start held high continuously is re-accepted on the first edge in IDLE.
- a, b and cin may change freely after capture without affecting the result.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag; cout is the carry.
- sum and cout change only on the DONE-entry edge or on reset.

Test Plan:
All cases use WIDTH=8.
1. Reset: hold reset_n=0 with random inputs -> busy=0, done=0, sum=8'h00, cout=0. Assert reset_n=0 asynchronously between clock edges -> outputs clear without waiting for a clock.
2. a=8'h0F, b=8'h01, cin=0, start pulsed at edge k -> busy=1 from k; done=1 only during cycle k+8..k+9; sum=8'h10, cout=0; busy=0 after k+9.
3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
4. start held high continuously; a/b changed to 8'hAA/8'h55 during ADD:
   - First result reflects the captured operands only.
   - Second accept occurs exactly 10 cycles after the first, giving sum=8'hFF, cout=0.
   - Exactly one done pulse per operation.
5. reset_n driven low during the 4th ADD cycle -> busy, done, sum and cout go to 0 immediately; no done appears. After release, a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
6. Random sweep of 200 operations against the reference model a+b+cin; sum/cout must stay stable between done pulses.
